// File: rtl/counter_pkg.sv
// Shared types for the general-purpose modulo counter family.
// Action and end-behaviour encodings are fixed two-bit codes so that
// parent blocks can drive them from plain register fields.
package counter_pkg;

   // What the counter does on the next rising edge.
   typedef enum bit [1:0] {
      HOLD       = 2'd0,
      COUNT_UP   = 2'd1,
      COUNT_DOWN = 2'd2,
      LOAD       = 2'd3
   } COUNTER_ACTION;

   // What the counter does when a count action hits a range boundary.
   // RESERVED is decoded exactly like WRAP.
   typedef enum bit [1:0] {
      WRAP     = 2'd0,
      SATURATE = 2'd1,
      ONESHOT  = 2'd2,
      RESERVED = 2'd3
   } COUNTER_END;

   // RUN counts normally; DONE is the parked state after a ONESHOT boundary.
   typedef enum logic [0:0] {
      RUN  = 1'b0,
      DONE = 1'b1
   } COUNTER_STATE;

   // Smallest legal counter width.
   localparam int min_word_width = 2;

endpackage

// File: rtl/counter_mod_if.sv
// Bus bundle between a counter and the block that controls it.
//
// There is no valid/ready handshake on this bus: control inputs are sampled
// on every rising edge, and cascade_in acts as a qualifier for count actions
// only. cascade_out of one stage is wired to cascade_in of the next so that a
// chain advances on a single edge.
interface counter_mod_if #(
   parameter int word_width = 8
) ();
   import counter_pkg::*;

   COUNTER_ACTION           action;
   COUNTER_END              end_mode;
   logic                    cascade_in;
   logic [word_width-1:0]   limit;
   logic [word_width-1:0]   D_IN;
   logic [word_width-1:0]   D_OUT;
   logic                    terminal;
   logic                    cascade_out;
   logic                    wrapped;
   logic                    done;
   COUNTER_STATE            state;     // observation of the internal state machine

   // Controller side: drives the command, observes the count.
   modport master (
      output action, end_mode, cascade_in, limit, D_IN,
      input  D_OUT, terminal, cascade_out, wrapped, done, state
   );

   // Counter side.
   modport slave (
      input  action, end_mode, cascade_in, limit, D_IN,
      output D_OUT, terminal, cascade_out, wrapped, done, state
   );

endinterface

// File: rtl/counter_boundary.sv
// Combinational decode for the counter: boundary detection, next count
// value and the events that the top-level registers and state machine need.
module counter_boundary
   import counter_pkg::*;
#(
   parameter int word_width = 8
) (
   input  logic [word_width-1:0] count,
   input  logic [word_width-1:0] limit,
   input  logic [word_width-1:0] d_in,
   input  COUNTER_ACTION         action,
   input  COUNTER_END            end_mode,
   input  logic                  cascade_in,
   input  logic                  in_run,
   output logic [word_width-1:0] next_value,
   output logic                  terminal,
   output logic                  wrap_event,
   output logic                  oneshot_hit
);

   localparam logic [word_width-1:0] zero = '0;
   localparam logic [word_width-1:0] one  = word_width'(1);

   logic up_bound;
   logic down_bound;
   logic count_ok;
   logic [word_width-1:0] load_value;

   // A count above a lowered limit still counts as the up boundary.
   assign up_bound   = (count >= limit);
   assign down_bound = (count == zero);
   // Count actions need the cascade qualifier and the RUN state.
   assign count_ok   = cascade_in & in_run;
   // Loads are clamped into [0, limit].
   assign load_value = (d_in > limit) ? limit : d_in;

   // Boundary flag seen by the next stage in the same cycle.
   assign terminal = count_ok &
                     (((action == COUNT_UP)   & up_bound) |
                      ((action == COUNT_DOWN) & down_bound));

   // Next value and boundary events for the action presented this cycle.
   always_comb begin
      next_value  = count;
      wrap_event  = 1'b0;
      oneshot_hit = 1'b0;
      case (action)
         COUNT_UP: begin
            if (count_ok) begin
               if (!up_bound) begin
                  next_value = count + one;
               end else begin
                  case (end_mode)
                     SATURATE: next_value = limit;
                     ONESHOT: begin
                        next_value  = limit;
                        oneshot_hit = 1'b1;
                     end
                     default: begin
                        next_value = zero;
                        wrap_event = 1'b1;
                     end
                  endcase
               end
            end
         end
         COUNT_DOWN: begin
            if (count_ok) begin
               if (!down_bound) begin
                  next_value = count - one;
               end else begin
                  case (end_mode)
                     SATURATE: next_value = zero;
                     ONESHOT: begin
                        next_value  = zero;
                        oneshot_hit = 1'b1;
                     end
                     default: begin
                        next_value = limit;
                        wrap_event = 1'b1;
                     end
                  endcase
               end
            end
         end
         LOAD:    next_value = load_value;
         default: next_value = count;
      endcase
   end

endmodule

// File: rtl/counter_mod.sv
// Modulo up/down counter with bounded range [0, limit], clamped load,
// WRAP/SATURATE/ONESHOT end behaviour and same-edge cascade chaining.
// Holds the count/flag registers and the RUN/DONE state machine; the
// arithmetic lives in counter_boundary.
module counter_mod
   import counter_pkg::*;
#(
   parameter int word_width  = 8,  // at least min_word_width
   parameter int reset_value = 0   // must fit in word_width bits
) (
   input  logic          clk,
   input  logic          reset,    // asynchronous, active low
   counter_mod_if.slave  bus
);

   COUNTER_STATE          state_q;
   COUNTER_STATE          state_d;
   logic [word_width-1:0] next_value;
   logic                  terminal;
   logic                  wrap_event;
   logic                  oneshot_hit;

   counter_boundary #(
      .word_width (word_width)
   ) u_boundary (
      .count       (bus.D_OUT),
      .limit       (bus.limit),
      .d_in        (bus.D_IN),
      .action      (bus.action),
      .end_mode    (bus.end_mode),
      .cascade_in  (bus.cascade_in),
      .in_run      (state_q == RUN),
      .next_value  (next_value),
      .terminal    (terminal),
      .wrap_event  (wrap_event),
      .oneshot_hit (oneshot_hit)
   );

   assign bus.terminal    = terminal;
   assign bus.cascade_out = terminal & bus.cascade_in;
   assign bus.state       = state_q;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: LOAD is the only way out of DONE; a ONESHOT boundary enters it.
   always_comb begin
      state_d = state_q;
      if (bus.action == LOAD) begin
         state_d = RUN;
      end else if (oneshot_hit) begin
         state_d = DONE;
      end
   end

   // Count and flag registers; wrapped is a one-cycle pulse per wrap,
   // done mirrors the state the machine is moving into.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.D_OUT   <= word_width'(reset_value);
         bus.wrapped <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         bus.D_OUT   <= next_value;
         bus.wrapped <= wrap_event;
         bus.done    <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod with word_width=4, reset_value=0.
// u_lo is the main instance; u_hi is chained behind it for the cascade test.
module tb_counter_mod;
   import counter_pkg::*;

   localparam int w = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   // Clock and reset
   always #5 clk = ~clk;

   counter_mod_if #(.word_width(w)) lo_bus ();
   counter_mod_if #(.word_width(w)) hi_bus ();

   assign hi_bus.cascade_in = lo_bus.cascade_out;

   counter_mod #(.word_width(w), .reset_value(0)) u_lo (
      .clk   (clk),
      .reset (reset),
      .bus   (lo_bus)
   );

   counter_mod #(.word_width(w), .reset_value(0)) u_hi (
      .clk   (clk),
      .reset (reset),
      .bus   (hi_bus)
   );

   // Scoreboard compare
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_lo(input logic [w-1:0] d);
      lo_bus.action = LOAD;
      lo_bus.D_IN   = d;
      tick();
      lo_bus.action = HOLD;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int seq[12];
      logic [31:0] prev;
      logic [31:0] e;
      int lo_wraps;
      int hi_wraps;

      lo_bus.action = HOLD; lo_bus.end_mode = WRAP; lo_bus.cascade_in = 1'b1;
      lo_bus.limit  = 4'd15; lo_bus.D_IN = 4'd0;
      hi_bus.action = HOLD; hi_bus.end_mode = WRAP;
      hi_bus.limit  = 4'd15; hi_bus.D_IN = 4'd0;

      // Reset state
      #12;
      check("rst_dout",    32'(lo_bus.D_OUT),   0);
      check("rst_done",    32'(lo_bus.done),    0);
      check("rst_wrapped", 32'(lo_bus.wrapped), 0);
      check("rst_state",   32'(lo_bus.state),   32'(RUN));
      check("rst_hi_dout", 32'(hi_bus.D_OUT),   0);
      @(negedge clk);
      reset = 1'b1;

      // 1. Reset mid-count, no clock edge needed
      lo_bus.action = COUNT_UP;
      repeat (5) tick();
      check("s1_count5", 32'(lo_bus.D_OUT), 5);
      lo_bus.action = HOLD;
      #2 reset = 1'b0;
      #1;
      check("s1_async_dout", 32'(lo_bus.D_OUT), 0);
      check("s1_async_done", 32'(lo_bus.done),  0);
      #2 reset = 1'b1;

      // 2. WRAP up with limit 9
      lo_bus.limit = 4'd9;
      seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      foreach (seq[i]) exp_q.push_back(32'(seq[i]));
      prev = 0;
      lo_bus.action = COUNT_UP;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("s2_terminal", 32'(lo_bus.terminal), 32'(prev == 9));
         tick();
         e = exp_q.pop_front();
         check("s2_dout",    32'(lo_bus.D_OUT),   e);
         check("s2_wrapped", 32'(lo_bus.wrapped), 32'(i == 9));
         prev = e;
      end
      lo_bus.action = HOLD;
      tick();
      check("s2_hold_dout",    32'(lo_bus.D_OUT),   2);
      check("s2_hold_wrapped", 32'(lo_bus.wrapped), 0);

      // 3. WRAP down from 0, then SATURATE down from 1
      load_lo(4'd0);
      check("s3_load0", 32'(lo_bus.D_OUT), 0);
      lo_bus.action = COUNT_DOWN;
      #1;
      check("s3_term_down", 32'(lo_bus.terminal), 1);
      tick();
      check("s3_wrap_dout",    32'(lo_bus.D_OUT),   9);
      check("s3_wrap_wrapped", 32'(lo_bus.wrapped), 1);
      lo_bus.end_mode = SATURATE;
      load_lo(4'd1);
      check("s3_load1",         32'(lo_bus.D_OUT),   1);
      check("s3_load1_wrapped", 32'(lo_bus.wrapped), 0);
      lo_bus.action = COUNT_DOWN;
      #1;
      check("s3_sat_term0", 32'(lo_bus.terminal), 0);
      tick();
      check("s3_sat_dout1",    32'(lo_bus.D_OUT),   0);
      check("s3_sat_wrapped1", 32'(lo_bus.wrapped), 0);
      check("s3_sat_term1",    32'(lo_bus.terminal), 1);
      tick();
      check("s3_sat_dout2",    32'(lo_bus.D_OUT),   0);
      check("s3_sat_wrapped2", 32'(lo_bus.wrapped), 0);
      lo_bus.action = HOLD;

      // Lowered limit and limit = 0
      load_lo(4'd8);
      check("lim_load8", 32'(lo_bus.D_OUT), 8);
      lo_bus.limit  = 4'd5;
      lo_bus.action = COUNT_UP;
      #1;
      check("lim_term_above", 32'(lo_bus.terminal), 1);
      tick();
      check("lim_sat_up", 32'(lo_bus.D_OUT), 5);
      lo_bus.end_mode = WRAP;
      lo_bus.limit    = 4'd3;
      lo_bus.action   = COUNT_DOWN;
      tick();
      check("lim_down_stale", 32'(lo_bus.D_OUT), 4);
      lo_bus.action = COUNT_UP;
      tick();
      check("lim_wrap_up",         32'(lo_bus.D_OUT),   0);
      check("lim_wrap_up_wrapped", 32'(lo_bus.wrapped), 1);
      lo_bus.limit = 4'd0;
      tick();
      check("lim0_dout_a",    32'(lo_bus.D_OUT),   0);
      check("lim0_wrapped_a", 32'(lo_bus.wrapped), 1);
      tick();
      check("lim0_dout_b",    32'(lo_bus.D_OUT),   0);
      check("lim0_wrapped_b", 32'(lo_bus.wrapped), 1);
      lo_bus.action = HOLD;
      tick();
      check("lim0_hold_wrapped", 32'(lo_bus.wrapped), 0);

      // 4. ONESHOT with clamped load
      lo_bus.limit    = 4'd10;
      lo_bus.end_mode = ONESHOT;
      load_lo(4'd13);
      check("s4_clamp", 32'(lo_bus.D_OUT), 10);
      lo_bus.action = COUNT_UP;
      #1;
      check("s4_term", 32'(lo_bus.terminal), 1);
      tick();
      check("s4_done",  32'(lo_bus.done),  1);
      check("s4_dout",  32'(lo_bus.D_OUT), 10);
      check("s4_state", 32'(lo_bus.state), 32'(DONE));
      check("s4_term_in_done", 32'(lo_bus.terminal), 0);
      tick();
      check("s4_ignored_dout", 32'(lo_bus.D_OUT), 10);
      check("s4_ignored_done", 32'(lo_bus.done),  1);
      lo_bus.end_mode = WRAP;
      tick();
      check("s4_mode_chg_dout",    32'(lo_bus.D_OUT),   10);
      check("s4_mode_chg_wrapped", 32'(lo_bus.wrapped), 0);
      check("s4_mode_chg_done",    32'(lo_bus.done),    1);
      load_lo(4'd3);
      check("s4_reload_dout",  32'(lo_bus.D_OUT), 3);
      check("s4_reload_done",  32'(lo_bus.done),  0);
      check("s4_reload_state", 32'(lo_bus.state), 32'(RUN));

      // Reset clears done asynchronously
      lo_bus.end_mode = ONESHOT;
      lo_bus.action   = COUNT_DOWN;
      repeat (4) tick();
      check("s1b_done_set", 32'(lo_bus.done),  1);
      check("s1b_dout0",    32'(lo_bus.D_OUT), 0);
      lo_bus.action = HOLD;
      #2 reset = 1'b0;
      #1;
      check("s1b_async_done",  32'(lo_bus.done),  0);
      check("s1b_async_state", 32'(lo_bus.state), 32'(RUN));
      #2 reset = 1'b1;

      // 6. cascade_in low blocks counting but not LOAD
      lo_bus.end_mode = WRAP;
      lo_bus.limit    = 4'd15;
      load_lo(4'd15);
      lo_bus.cascade_in = 1'b0;
      lo_bus.action     = COUNT_UP;
      #1;
      check("s6_term",     32'(lo_bus.terminal),    0);
      check("s6_cout",     32'(lo_bus.cascade_out), 0);
      tick();
      check("s6_hold",     32'(lo_bus.D_OUT),   15);
      check("s6_wrapped",  32'(lo_bus.wrapped), 0);
      load_lo(4'd6);
      check("s6_load",     32'(lo_bus.D_OUT), 6);
      lo_bus.cascade_in = 1'b1;

      // 5. Two-stage 8-bit cascade
      lo_bus.action = LOAD; lo_bus.D_IN = 4'd0;
      hi_bus.action = LOAD; hi_bus.D_IN = 4'd0;
      tick();
      check("s5_start", 32'({hi_bus.D_OUT, lo_bus.D_OUT}), 0);
      lo_bus.action = COUNT_UP;
      hi_bus.action = COUNT_UP;
      lo_wraps = 0;
      hi_wraps = 0;
      for (int i = 1; i <= 256; i++) begin
         tick();
         check("s5_count", 32'({hi_bus.D_OUT, lo_bus.D_OUT}), 32'(i % 256));
         if (lo_bus.wrapped) lo_wraps++;
         if (hi_bus.wrapped) hi_wraps++;
         if (i == 256) begin
            check("s5_lo_wrapped_256", 32'(lo_bus.wrapped), 1);
            check("s5_hi_wrapped_256", 32'(hi_bus.wrapped), 1);
         end
      end
      check("s5_lo_wraps", 32'(lo_wraps), 16);
      check("s5_hi_wraps", 32'(hi_wraps), 1);
      lo_bus.action = HOLD;
      hi_bus.action = HOLD;

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter with bounded range, load, selectable end behaviour and cascade chaining. It is the next-generation general counter for the std utility set, replacing separate forward/backward/loadable counters with one block. Timers, address generators and baud dividers instantiate it directly. Wider counts are built by chaining several instances through `cascade_in`/`cascade_out`.

## Interface
Parameters:
- `word_width`, default 8: counter width; must be ≥ 2.
- `reset_value`, default 0: value of `D_OUT` after reset; must be ≤ 2**word_width-1.

Ports:
- `clk` in, 1: clock; all state changes on the rising edge.
- `reset` in, 1: asynchronous, active-low reset.
- `action` in, 2: `COUNTER_ACTION` (HOLD, COUNT_UP, COUNT_DOWN, LOAD).
- `end_mode` in, 2: `COUNTER_END` (WRAP, SATURATE, ONESHOT, RESERVED; RESERVED behaves as WRAP).
- `cascade_in` in, 1: count qualifier; count actions take effect only when high. Tie to 1 when standalone.
- `limit` in, word_width: upper bound of the count range [0, limit].
- `D_IN` in, word_width: load value.
- `D_OUT` out, word_width: registered count.
- `terminal` out, 1: combinational; the current count action hits a boundary this cycle.
- `cascade_out` out, 1: `terminal & cascade_in`; drives the next stage's `cascade_in`.
- `wrapped` out, 1: registered one-cycle pulse after a WRAP-mode wrap.
- `done` out, 1: registered; ONESHOT boundary reached.

## Operation
- Internal state machine, 2 states:
  - RUN (reset state).
  - DONE (entered only in ONESHOT mode).
- Up boundary is `D_OUT >= limit`. Down boundary is `D_OUT == 0`.
- `terminal` = `cascade_in` & state==RUN & ((COUNT_UP & up boundary) | (COUNT_DOWN & down boundary)).
- HOLD, or a count action with `cascade_in`=0: `D_OUT` is unchanged; `wrapped` goes to 0.
- COUNT_UP, RUN, not at boundary: `D_OUT`+1.
- COUNT_UP, RUN, at boundary:
  - WRAP: `D_OUT`←0; `wrapped`←1.
  - SATURATE: `D_OUT`←`limit`.
  - ONESHOT: `D_OUT`←`limit`; state→DONE; `done`←1.
- COUNT_DOWN, RUN, not at boundary: `D_OUT`-1.
- COUNT_DOWN, RUN, at boundary:
  - WRAP: `D_OUT`←`limit`; `wrapped`←1.
  - SATURATE: `D_OUT` holds 0.
  - ONESHOT: `D_OUT` holds 0; state→DONE; `done`←1.
- DONE state: count actions are ignored and `D_OUT` holds. `terminal`=0.
- LOAD (independent of `cascade_in`):
  - `D_OUT`←min(`D_IN`, `limit`).
  - state→RUN; `done`←0; `wrapped`←0.
  - LOAD is the only exit from DONE.
- `limit` lowered below the current `D_OUT`:
  - COUNT_UP treats it as a boundary (WRAP→0, SATURATE/ONESHOT→`limit`).
  - COUNT_DOWN decrements normally.
- `limit`=0: COUNT_UP in WRAP mode keeps `D_OUT`=0 and pulses `wrapped` every cycle.
- `end_mode` changing while in DONE has no effect until the next LOAD.
- Arithmetic is modulo 2**word_width internally. No result exceeds `limit`, except a stale `D_OUT` left above a lowered `limit` under HOLD or COUNT_DOWN.

## Timing
- Reset asserted (low), any time including mid-count: immediately `D_OUT`=`reset_value`, `wrapped`=0, `done`=0, state=RUN.
- Release is synchronous to `clk` at the integrating level; the block itself has no reset-release filtering.
- Latency: `action` sampled at edge N; `D_OUT`, `wrapped` and `done` reflect it after edge N.
- `terminal`/`cascade_out` are valid in the same cycle as `action`/`cascade_in`, with no register stage, so chained stages advance on the same edge.
- `wrapped` is high for exactly one cycle per wrap. Consecutive wraps give consecutive high cycles.

## Structure
- Shared package `counter_pkg`:
  - `COUNTER_ACTION` enum bit[1:0] {HOLD, COUNT_UP, COUNT_DOWN, LOAD}.
  - `COUNTER_END` enum bit[1:0] {WRAP, SATURATE, ONESHOT, RESERVED}.
  - `COUNTER_STATE` enum {RUN, DONE}.
- One sub-module is natural: `counter_boundary`, purely combinational, computing up/down boundary, next value and `terminal` from `D_OUT`, `limit`, `action` and `end_mode`.
- The top module holds the registers and the state machine.

## Test plan
All scenarios use word_width=4, reset_value=0.

1. Reset mid-count: count to 5, pull `reset` low between edges → `D_OUT`=0 and `done`=0 immediately, without a clock edge.
2. WRAP up, `limit`=9: 12 COUNT_UP cycles → `D_OUT` 1..9,0,1,2; `terminal` high in the cycle `D_OUT`=9; `wrapped` high in the one cycle `D_OUT`=0.
3. WRAP down, `limit`=9, from 0: COUNT_DOWN → `D_OUT`=9 and `wrapped`=1. SATURATE down from 1: two COUNT_DOWN → 0, 0, with no `wrapped` pulse.
4. ONESHOT: LOAD `D_IN`=13 with `limit`=10 → `D_OUT`=10. COUNT_UP → `done`=1, `D_OUT`=10. Further COUNT_UP → unchanged. LOAD 3 → `D_OUT`=3, `done`=0.
5. Cascade: two instances with `limit`=15 each, forming an 8-bit count, 256 COUNT_UP cycles → low stage wraps 16 times; high stage advances only when low `cascade_out`=1; after 255 cycles the combined value is 0xFF; cycle 256 gives 0x00 with both stages pulsing `wrapped`.
6. `cascade_in`=0 with COUNT_UP: `D_OUT` holds and `terminal`=0. LOAD with `cascade_in`=0 still loads.
